// File: rtl/bit_sayici_cok_cevrim.sv
// Multi-cycle Zbb bit counter (CTZ, CLZ, CPOP) on a 32-bit operand.
// Scans one byte per cycle; CTZ/CLZ stop at the first nonzero byte.
module bit_sayici_cok_cevrim (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        istek_gecerli_i,
  output logic        istek_hazir_o,
  input  logic [31:0] deger_i,
  input  logic [1:0]  islem_i,
  output logic [5:0]  sonuc_o,
  output logic        sonuc_gecerli_o,
  input  logic        sonuc_hazir_i
);

  typedef enum logic [1:0] {
    BOS     = 2'b00,
    HESAPLA = 2'b01,
    SONUC   = 2'b10
  } durum_t;

  localparam logic [1:0] ISLEM_CPOP = 2'b01;
  localparam logic [1:0] ISLEM_CLZ  = 2'b10;

  durum_t      durum;
  logic [31:0] r;
  logic [31:0] ters;
  logic [1:0]  islem;
  logic [1:0]  k;
  logic [5:0]  acc;
  logic        hazir;
  logic        gecerli;
  logic [5:0]  sonuc;

  logic [7:0]  bayt;
  logic [3:0]  ekle;
  logic        bitti;
  logic [5:0]  toplam;

  // CLZ is run as CTZ on the bit-reversed operand.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_ters
      assign ters[gi] = deger_i[31-gi];
    end
  endgenerate

  // Trailing zeros of a byte; an all-zero byte yields 8.
  function automatic logic [3:0] sifir_say(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) n = 4'(i);
    end
    return n;
  endfunction

  function automatic logic [3:0] bir_say(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

  always_comb begin
    bayt   = r[{k, 3'b000} +: 8];
    ekle   = 4'd0;
    bitti  = 1'b0;
    if (islem == ISLEM_CPOP) begin
      ekle  = bir_say(bayt);
      bitti = (k == 2'd3);
    end else begin
      ekle  = sifir_say(bayt);
      bitti = (bayt != 8'h00) || (k == 2'd3);
    end
    toplam = acc + {2'b00, ekle};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum   <= BOS;
      r       <= 32'h0;
      islem   <= 2'b00;
      acc     <= 6'd0;
      k       <= 2'd0;
      hazir   <= 1'b1;
      gecerli <= 1'b0;
      sonuc   <= 6'd0;
    end else begin
      case (durum)
        BOS: begin
          if (istek_gecerli_i && hazir) begin
            r     <= (islem_i == ISLEM_CLZ) ? ters : deger_i;
            islem <= islem_i;
            acc   <= 6'd0;
            k     <= 2'd0;
            hazir <= 1'b0;
            durum <= HESAPLA;
          end
        end
        HESAPLA: begin
          acc <= toplam;
          k   <= k + 2'd1;
          if (bitti) begin
            gecerli <= 1'b1;
            sonuc   <= toplam;
            durum   <= SONUC;
          end
        end
        SONUC: begin
          if (gecerli && sonuc_hazir_i) begin
            gecerli <= 1'b0;
            sonuc   <= 6'd0;
            hazir   <= 1'b1;
            durum   <= BOS;
          end
        end
        default: begin
          durum   <= BOS;
          hazir   <= 1'b1;
          gecerli <= 1'b0;
          sonuc   <= 6'd0;
        end
      endcase
    end
  end

  assign istek_hazir_o   = hazir;
  assign sonuc_gecerli_o = gecerli;
  assign sonuc_o         = sonuc;

endmodule

// File: tb/tb_bit_sayici_cok_cevrim.sv
// Directed, table-driven bench for bit_sayici_cok_cevrim: results, latency,
// backpressure and asynchronous reset in the middle of an operation.
module tb_bit_sayici_cok_cevrim;

  logic        clk;
  logic        rst_n;
  logic        istek_gecerli;
  logic        istek_hazir;
  logic [31:0] deger;
  logic [1:0]  islem;
  logic [5:0]  sonuc;
  logic        sonuc_gecerli;
  logic        sonuc_hazir;

  int checks   = 0;
  int failures = 0;

  bit_sayici_cok_cevrim dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .istek_gecerli_i (istek_gecerli),
    .istek_hazir_o   (istek_hazir),
    .deger_i         (deger),
    .islem_i         (islem),
    .sonuc_o         (sonuc),
    .sonuc_gecerli_o (sonuc_gecerli),
    .sonuc_hazir_i   (sonuc_hazir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] deger;
    logic [1:0]  islem;
    logic [5:0]  beklenen;
    int          gecikme;
  } vektor_t;

  vektor_t tablo[13];

  task automatic chk(input string ad, input int gercek, input int beklenen);
    checks++;
    if (gercek != beklenen) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", ad, gercek, beklenen);
    end
  endtask

  // One full transaction: accept, measure latency, check result, drain.
  task automatic islem_yap(input logic [31:0] d, input logic [1:0] op,
                           input logic [5:0] bek, input int bek_lat);
    int         lat;
    logic [5:0] got;
    @(negedge clk);
    istek_gecerli = 1'b1;
    deger         = d;
    islem         = op;
    sonuc_hazir   = 1'b0;
    @(posedge clk);
    #1;
    istek_gecerli = 1'b0;
    deger         = $urandom;
    islem         = 2'($urandom_range(0, 3));
    chk("busy_after_accept", int'(istek_hazir), 0);
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (sonuc_gecerli) lat = n;
    end
    got = sonuc;
    chk("latency", lat, bek_lat);
    chk("result", int'(got), int'(bek));
    $display("op deger=%08h islem=%0d sonuc=%0d latency=%0d", d, op, got, lat);
    @(negedge clk);
    sonuc_hazir = 1'b1;
    @(posedge clk);
    #1;
    sonuc_hazir = 1'b0;
    chk("valid_drop", int'(sonuc_gecerli), 0);
    chk("ready_back", int'(istek_hazir), 1);
  endtask

  initial begin
    tablo[0]  = '{32'h0000_0100, 2'b00, 6'd8,  2};
    tablo[1]  = '{32'h0000_0001, 2'b00, 6'd0,  1};
    tablo[2]  = '{32'h0000_0000, 2'b00, 6'd32, 4};
    tablo[3]  = '{32'h8000_0000, 2'b00, 6'd31, 4};
    tablo[4]  = '{32'h00F0_0000, 2'b00, 6'd20, 3};
    tablo[5]  = '{32'h0001_0000, 2'b10, 6'd15, 2};
    tablo[6]  = '{32'h0000_0000, 2'b10, 6'd32, 4};
    tablo[7]  = '{32'hFFFF_FFFF, 2'b10, 6'd0,  1};
    tablo[8]  = '{32'h0000_0001, 2'b10, 6'd31, 4};
    tablo[9]  = '{32'hFFFF_FFFF, 2'b01, 6'd32, 4};
    tablo[10] = '{32'hF0F0_0001, 2'b01, 6'd9,  4};
    tablo[11] = '{32'h0000_0000, 2'b01, 6'd0,  4};
    tablo[12] = '{32'h0000_0100, 2'b11, 6'd8,  2};

    rst_n         = 1'b0;
    istek_gecerli = 1'b0;
    deger         = 32'h0;
    islem         = 2'b00;
    sonuc_hazir   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", int'(istek_hazir), 1);
    chk("reset_valid", int'(sonuc_gecerli), 0);
    chk("reset_result", int'(sonuc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      islem_yap(tablo[i].deger, tablo[i].islem, tablo[i].beklenen, tablo[i].gecikme);
    end

    // Backpressure: result must hold while the consumer stalls.
    @(negedge clk);
    istek_gecerli = 1'b1;
    deger         = 32'h0000_0100;
    islem         = 2'b00;
    @(posedge clk);
    #1;
    istek_gecerli = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_valid_at_2", int'(sonuc_gecerli), 1);
    for (int c = 0; c < 5; c++) begin
      deger = $urandom;
      islem = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      chk("bp_hold_result", int'(sonuc), 8);
      chk("bp_hold_valid", int'(sonuc_gecerli), 1);
      chk("bp_not_ready", int'(istek_hazir), 0);
    end
    $display("backpressure sonuc=%0d held 5 cycles", sonuc);
    @(negedge clk);
    sonuc_hazir = 1'b1;
    @(posedge clk);
    #1;
    sonuc_hazir = 1'b0;
    chk("bp_release_valid", int'(sonuc_gecerli), 0);
    chk("bp_release_ready", int'(istek_hazir), 1);

    // Asynchronous reset two edges into a CPOP.
    @(negedge clk);
    istek_gecerli = 1'b1;
    deger         = 32'hFFFF_FFFF;
    islem         = 2'b01;
    @(posedge clk);
    #1;
    istek_gecerli = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", int'(istek_hazir), 1);
    chk("rst_mid_valid", int'(sonuc_gecerli), 0);
    chk("rst_mid_result", int'(sonuc), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_valid", int'(sonuc_gecerli), 0);
    $display("reset mid-operation istek_hazir=%0d sonuc_gecerli=%0d", istek_hazir, sonuc_gecerli);
    @(negedge clk);
    rst_n = 1'b1;
    islem_yap(32'h0000_0004, 2'b00, 6'd2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
